// File: rtl/add_icb_pkg.sv
// Shared types and constants for the adder-accelerator ICB initiator.
package add_icb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_RSP  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        STEP_AUGEND  = 3'd0,
        STEP_ADDEND  = 3'd1,
        STEP_CONTROL = 3'd2,
        STEP_SUM     = 3'd3,
        STEP_STATUS  = 3'd4
    } step_e;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h1004_2000;
    localparam logic [31:0] DEF_OFF_AUGEND  = 32'h0000_0000;
    localparam logic [31:0] DEF_OFF_ADDEND  = 32'h0000_0004;
    localparam logic [31:0] DEF_OFF_CONTROL = 32'h0000_0008;
    localparam logic [31:0] DEF_OFF_SUM     = 32'h0000_000C;
    localparam logic [31:0] DEF_OFF_STATUS  = 32'h0000_0010;

    localparam logic [31:0] CTRL_ENABLE = 32'h0000_0001;
    localparam logic [3:0]  WMASK_WR    = 4'hF;
    localparam logic [3:0]  WMASK_RD    = 4'h0;

    typedef struct packed {
        logic        read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } icb_cmd_t;

endpackage

// File: rtl/add_icb_master.sv
// ICB initiator: writes an operand pair and enable to the adder slave, waits,
// then reads back SUM and STATUS and presents them on a local result port.
module add_icb_master
    import add_icb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0] OFF_AUGEND  = DEF_OFF_AUGEND,
    parameter logic [31:0] OFF_ADDEND  = DEF_OFF_ADDEND,
    parameter logic [31:0] OFF_CONTROL = DEF_OFF_CONTROL,
    parameter logic [31:0] OFF_SUM     = DEF_OFF_SUM,
    parameter logic [31:0] OFF_STATUS  = DEF_OFF_STATUS,
    parameter int unsigned SETTLE      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_sum,
    output logic        res_overflow,
    output logic        res_err,
    output logic        icb_cmd_valid,
    input  logic        icb_cmd_ready,
    output logic        icb_cmd_read,
    output logic [31:0] icb_cmd_addr,
    output logic [31:0] icb_cmd_wdata,
    output logic [3:0]  icb_cmd_wmask,
    input  logic        icb_rsp_valid,
    output logic        icb_rsp_ready,
    input  logic [31:0] icb_rsp_rdata,
    input  logic        icb_rsp_err
);

    localparam logic       HAS_SETTLE  = (SETTLE > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_e      state_r, state_nx;
    step_e       step_r, step_nx;
    logic [3:0]  wait_cnt_r, wait_cnt_nx;
    logic [31:0] a_r, a_nx, b_r, b_nx;
    logic [31:0] sum_r, sum_nx;
    logic        ovf_r, ovf_nx;
    logic        err_r, err_nx;
    icb_cmd_t    cmd_r, cmd_nx;
    logic        req_ready_r, cmd_valid_r, rsp_ready_r, res_valid_r;

    function automatic icb_cmd_t step_cmd(input step_e step, input logic [31:0] a,
                                          input logic [31:0] b);
        icb_cmd_t c;
        c.read  = 1'b0;
        c.addr  = BASE_ADDR + OFF_AUGEND;
        c.wdata = a;
        c.wmask = WMASK_WR;
        case (step)
            STEP_AUGEND: begin
                c.addr  = BASE_ADDR + OFF_AUGEND;
                c.wdata = a;
            end
            STEP_ADDEND: begin
                c.addr  = BASE_ADDR + OFF_ADDEND;
                c.wdata = b;
            end
            STEP_CONTROL: begin
                c.addr  = BASE_ADDR + OFF_CONTROL;
                c.wdata = CTRL_ENABLE;
            end
            STEP_SUM: begin
                c.read  = 1'b1;
                c.addr  = BASE_ADDR + OFF_SUM;
                c.wdata = 32'h0000_0000;
                c.wmask = WMASK_RD;
            end
            STEP_STATUS: begin
                c.read  = 1'b1;
                c.addr  = BASE_ADDR + OFF_STATUS;
                c.wdata = 32'h0000_0000;
                c.wmask = WMASK_RD;
            end
            default: begin
                c.read  = 1'b0;
            end
        endcase
        return c;
    endfunction

    // Next-state, step sequencing and result capture.
    always_comb begin
        state_nx    = state_r;
        step_nx     = step_r;
        wait_cnt_nx = wait_cnt_r;
        a_nx        = a_r;
        b_nx        = b_r;
        sum_nx      = sum_r;
        ovf_nx      = ovf_r;
        err_nx      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    a_nx     = req_a;
                    b_nx     = req_b;
                    step_nx  = STEP_AUGEND;
                    sum_nx   = 32'h0000_0000;
                    ovf_nx   = 1'b0;
                    err_nx   = 1'b0;
                    state_nx = ST_CMD;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (icb_cmd_ready) begin
                    state_nx = ST_RSP;
                end else begin
                    state_nx = ST_CMD;
                end
            end
            ST_RSP: begin
                if (!icb_rsp_valid) begin
                    state_nx = ST_RSP;
                end else if (icb_rsp_err) begin
                    // An errored run reports a zero result regardless of earlier reads.
                    err_nx   = 1'b1;
                    sum_nx   = 32'h0000_0000;
                    ovf_nx   = 1'b0;
                    state_nx = ST_DONE;
                end else begin
                    if (step_r == STEP_SUM) begin
                        sum_nx = icb_rsp_rdata;
                    end else begin
                        sum_nx = sum_r;
                    end
                    if (step_r == STEP_STATUS) begin
                        ovf_nx = icb_rsp_rdata[0];
                    end else begin
                        ovf_nx = ovf_r;
                    end
                    if (step_r == STEP_CONTROL && HAS_SETTLE) begin
                        wait_cnt_nx = 4'd0;
                        state_nx    = ST_WAIT;
                    end else if (step_r == STEP_STATUS) begin
                        state_nx = ST_DONE;
                    end else begin
                        step_nx  = step_e'(step_r + 3'd1);
                        state_nx = ST_CMD;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == SETTLE_LAST) begin
                    step_nx  = STEP_SUM;
                    state_nx = ST_CMD;
                end else begin
                    wait_cnt_nx = wait_cnt_r + 4'd1;
                    state_nx    = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    err_nx   = 1'b0;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        cmd_nx = step_cmd(step_nx, a_nx, b_nx);
    end

    // State, datapath and output registers; handshake outputs follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            step_r      <= STEP_AUGEND;
            wait_cnt_r  <= 4'd0;
            a_r         <= 32'h0000_0000;
            b_r         <= 32'h0000_0000;
            sum_r       <= 32'h0000_0000;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            cmd_r       <= '0;
            req_ready_r <= 1'b1;
            cmd_valid_r <= 1'b0;
            rsp_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx;
            step_r      <= step_nx;
            wait_cnt_r  <= wait_cnt_nx;
            a_r         <= a_nx;
            b_r         <= b_nx;
            sum_r       <= sum_nx;
            ovf_r       <= ovf_nx;
            err_r       <= err_nx;
            if (state_nx == ST_CMD) begin
                cmd_r <= cmd_nx;
            end
            req_ready_r <= (state_nx == ST_IDLE);
            cmd_valid_r <= (state_nx == ST_CMD);
            rsp_ready_r <= (state_nx == ST_RSP);
            res_valid_r <= (state_nx == ST_DONE);
        end
    end

    assign req_ready     = req_ready_r;
    assign res_valid     = res_valid_r;
    assign res_sum       = sum_r;
    assign res_overflow  = ovf_r;
    assign res_err       = err_r;
    assign icb_cmd_valid = cmd_valid_r;
    assign icb_cmd_read  = cmd_r.read;
    assign icb_cmd_addr  = cmd_r.addr;
    assign icb_cmd_wdata = cmd_r.wdata;
    assign icb_cmd_wmask = cmd_r.wmask;
    assign icb_rsp_ready = rsp_ready_r;

endmodule
